multicycle_control_unit: RTL and testbench

- Parametrised, FSM-sequenced successor to the single-stage decoder.
- Accepts one 32-bit instruction per fetch through a valid/ready handshake and latches it into an internal IR.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/COMMIT, driving datapath selects, register-file and data-memory enables, and a one-cycle PC advance pulse.
- Sits between instruction memory and the datapath (register file, ALU, data memory, PC mux).

---
 rtl/multicycle_control_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/COMMIT sequencer with registered datapath controls.
// Optional MULTICYCLE_CU_PERF_EN adds perf_cycles / perf_retired counters.
module multicycle_control_unit #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned TMO_W       = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instruction,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic              mem_ready,
   output logic [4:0]        reg1,
   output logic [4:0]        reg2,
   output logic [4:0]        reg3,
   output logic [4:0]        s_r_amount,
   output logic [DATA_W-1:0] im_data,
   output logic [4:0]        alu_opcode,
   output logic [1:0]        jump_mux_signal,
   output logic              write_back_on_register_mux_signal,
   output logic              alu_input_mux_signal,
   output logic              register_write_word_enable,
   output logic              register_write_byte_enable,
   output logic              memwrite_enable_a,
   output logic              memwrite_enable_b,
   output logic              memread_enable_a,
   output logic              memread_enable_b,
   output logic              PC_enable,
   output logic              halted,
   output logic              bus_error
`ifdef MULTICYCLE_CU_PERF_EN
   ,
   output logic [31:0]       perf_cycles,
   output logic [31:0]       perf_retired
`endif
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_COMMIT,
      S_HALT
   } state_t;

   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);
   localparam bit               TMO_EN    = (MEM_TIMEOUT != 0);

   state_t           state;
   logic [31:0]      ir;
   logic [TMO_W-1:0] tmo_cnt;
   logic [TMO_W-1:0] tmo_next;

   logic [5:0]       op;
   logic [3:0]       sub;
   logic             is_mem;
   logic             c_word_wr;
   logic             c_byte_wr;

   logic [4:0]        d_reg1, d_reg2, d_reg3, d_sr, d_alu;
   logic [1:0]        d_jump;
   logic              d_wb, d_ain;
   logic [DATA_W-1:0] d_im;

   assign op        = ir[31:26];
   assign sub       = ir[29:26];
   assign is_mem    = (op[5:2] == 4'b0110);
   assign c_word_wr = (op != 6'd0) && (op <= 6'd24);
   assign c_byte_wr = (op == 6'd26);
   assign tmo_next  = tmo_cnt + 1'b1;
   assign d_im      = {{(DATA_W-16){ir[15]}}, ir[15:0]};

   always_comb begin
      d_reg1 = '0;
      d_reg2 = '0;
      d_reg3 = '0;
      d_sr   = '0;
      d_alu  = '0;
      d_jump = '0;
      d_wb   = 1'b0;
      d_ain  = 1'b0;
      if (op == 6'd0) begin
         d_wb = 1'b0;
      end else if (op <= 6'd15) begin
         d_reg3 = ir[25:21];
         d_reg1 = ir[20:16];
         d_reg2 = ir[15:11];
         d_sr   = ir[10:6];
         d_alu  = {1'b0, sub};
         d_wb   = 1'b1;
      end else if (op <= 6'd23) begin
         d_reg3 = ir[25:21];
         d_reg1 = ir[20:16];
         d_ain  = 1'b1;
         d_wb   = 1'b1;
         case (sub)
            4'd2:    d_alu = 5'd1;
            4'd3:    d_alu = 5'd2;
            4'd4:    d_alu = 5'd3;
            4'd5:    d_alu = 5'd4;
            4'd6:    d_alu = 5'd9;
            4'd7:    d_alu = 5'd10;
            default: d_alu = 5'd0;
         endcase
      end else if (op <= 6'd27) begin
         d_reg1 = ir[20:16];
         d_reg2 = ir[25:21];
         d_reg3 = ir[25:21];
         d_alu  = 5'd1;
         d_ain  = 1'b1;
      end else begin
         d_reg1 = ir[25:21];
         d_reg2 = ir[20:16];
         d_wb   = 1'b1;
         if (op == 6'd28)      d_jump = 2'd3;
         else if (op == 6'd29) d_jump = 2'd2;
         else                  d_jump = 2'd1;
         if (sub == 4'd14)      d_alu = 5'd16;
         else if (sub == 4'd15) d_alu = 5'd15;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                             <= S_FETCH;
         ir                                <= '0;
         tmo_cnt                           <= '0;
         instr_ready                       <= 1'b1;
         reg1                              <= '0;
         reg2                              <= '0;
         reg3                              <= '0;
         s_r_amount                        <= '0;
         im_data                           <= '0;
         alu_opcode                        <= '0;
         jump_mux_signal                   <= '0;
         write_back_on_register_mux_signal <= 1'b0;
         alu_input_mux_signal              <= 1'b0;
         register_write_word_enable        <= 1'b0;
         register_write_byte_enable        <= 1'b0;
         memwrite_enable_a                 <= 1'b0;
         memwrite_enable_b                 <= 1'b0;
         memread_enable_a                  <= 1'b0;
         memread_enable_b                  <= 1'b0;
         PC_enable                         <= 1'b0;
         halted                            <= 1'b0;
         bus_error                         <= 1'b0;
      end else begin
         PC_enable                  <= 1'b0;
         register_write_word_enable <= 1'b0;
         register_write_byte_enable <= 1'b0;
         case (state)
            S_FETCH: begin
               if (instr_valid) begin
                  ir          <= instruction;
                  instr_ready <= 1'b0;
                  state       <= S_DECODE;
               end
            end
            S_DECODE: begin
               reg1                              <= d_reg1;
               reg2                              <= d_reg2;
               reg3                              <= d_reg3;
               s_r_amount                        <= d_sr;
               im_data                           <= d_im;
               alu_opcode                        <= d_alu;
               jump_mux_signal                   <= d_jump;
               write_back_on_register_mux_signal <= d_wb;
               alu_input_mux_signal              <= d_ain;
               if (op == 6'd0) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (is_mem) begin
                  tmo_cnt           <= '0;
                  memread_enable_a  <= (op[1:0] == 2'd0);
                  memwrite_enable_a <= (op[1:0] == 2'd1);
                  memread_enable_b  <= (op[1:0] == 2'd2);
                  memwrite_enable_b <= (op[1:0] == 2'd3);
                  state             <= S_MEM;
               end else begin
                  PC_enable                  <= 1'b1;
                  register_write_word_enable <= c_word_wr;
                  register_write_byte_enable <= c_byte_wr;
                  state                      <= S_COMMIT;
               end
            end
            S_MEM: begin
               // completion is checked first so a late mem_ready beats the timeout
               if (mem_ready) begin
                  memread_enable_a           <= 1'b0;
                  memwrite_enable_a          <= 1'b0;
                  memread_enable_b           <= 1'b0;
                  memwrite_enable_b          <= 1'b0;
                  PC_enable                  <= 1'b1;
                  register_write_word_enable <= c_word_wr;
                  register_write_byte_enable <= c_byte_wr;
                  state                      <= S_COMMIT;
               end else if (TMO_EN && (tmo_next == TMO_LIMIT)) begin
                  memread_enable_a  <= 1'b0;
                  memwrite_enable_a <= 1'b0;
                  memread_enable_b  <= 1'b0;
                  memwrite_enable_b <= 1'b0;
                  bus_error         <= 1'b1;
                  halted            <= 1'b1;
                  state             <= S_HALT;
               end else begin
                  tmo_cnt <= tmo_next;
               end
            end
            S_COMMIT: begin
               instr_ready <= 1'b1;
               state       <= S_FETCH;
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               instr_ready <= 1'b1;
               state       <= S_FETCH;
            end
         endcase
      end
   end

`ifdef MULTICYCLE_CU_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_cycles  <= '0;
         perf_retired <= '0;
      end else begin
         if (!halted)   perf_cycles  <= perf_cycles + 32'd1;
         if (PC_enable) perf_retired <= perf_retired + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: expected commit/halt records are queued at issue
// and checked by a monitor whenever PC_enable pulses or halted rises.
module tb_multicycle_control_unit;

   typedef struct {
      logic        halt;
      logic        berr;
      logic [4:0]  r1, r2, r3, sr, alu;
      logic [31:0] im;
      logic [1:0]  jmp;
      logic        wb, ain, rww, rwb;
      int          lat;
      logic [3:0]  smask;
      int          scnt;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        instr_ready;
   logic        mem_ready;
   logic [4:0]  reg1, reg2, reg3, s_r_amount, alu_opcode;
   logic [31:0] im_data;
   logic [1:0]  jump_mux_signal;
   logic        write_back_on_register_mux_signal, alu_input_mux_signal;
   logic        register_write_word_enable, register_write_byte_enable;
   logic        memwrite_enable_a, memwrite_enable_b, memread_enable_a, memread_enable_b;
   logic        PC_enable, halted, bus_error;
`ifdef MULTICYCLE_CU_PERF_EN
   logic [31:0] perf_cycles, perf_retired;
`endif

   exp_t q[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   cyc      = 0;
   int   accept_cyc = 0;
   int   mem_wait = -1;
   logic idle_ready = 1'b1;

   multicycle_control_unit #(.DATA_W(32), .MEM_TIMEOUT(15), .TMO_W(4)) dut (
      .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .mem_ready(mem_ready),
      .reg1(reg1), .reg2(reg2), .reg3(reg3), .s_r_amount(s_r_amount), .im_data(im_data),
      .alu_opcode(alu_opcode), .jump_mux_signal(jump_mux_signal),
      .write_back_on_register_mux_signal(write_back_on_register_mux_signal),
      .alu_input_mux_signal(alu_input_mux_signal),
      .register_write_word_enable(register_write_word_enable),
      .register_write_byte_enable(register_write_byte_enable),
      .memwrite_enable_a(memwrite_enable_a), .memwrite_enable_b(memwrite_enable_b),
      .memread_enable_a(memread_enable_a), .memread_enable_b(memread_enable_b),
      .PC_enable(PC_enable), .halted(halted), .bus_error(bus_error)
`ifdef MULTICYCLE_CU_PERF_EN
      , .perf_cycles(perf_cycles), .perf_retired(perf_retired)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic any_out();
      return |{reg1, reg2, reg3, s_r_amount, im_data, alu_opcode, jump_mux_signal,
               write_back_on_register_mux_signal, alu_input_mux_signal,
               register_write_word_enable, register_write_byte_enable,
               memwrite_enable_a, memwrite_enable_b, memread_enable_a, memread_enable_b,
               PC_enable, halted, bus_error};
   endfunction

   function automatic exp_t ec(logic [4:0] r1, logic [4:0] r2, logic [4:0] r3, logic [4:0] sr,
                               logic [31:0] im, logic [4:0] alu, logic [1:0] jmp,
                               logic wb, logic ain, logic rww, logic rwb,
                               int lat, logic [3:0] sm, int sc);
      exp_t e;
      e.halt = 1'b0; e.berr = 1'b0;
      e.r1 = r1; e.r2 = r2; e.r3 = r3; e.sr = sr; e.im = im; e.alu = alu; e.jmp = jmp;
      e.wb = wb; e.ain = ain; e.rww = rww; e.rwb = rwb;
      e.lat = lat; e.smask = sm; e.scnt = sc;
      return e;
   endfunction

   function automatic exp_t eh(logic berr, int lat, int sc);
      exp_t e;
      e = ec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, lat, 4'b0000, sc);
      e.halt  = 1'b1;
      e.berr  = berr;
      e.smask = (sc != 0) ? 4'b0100 : 4'b0000;
      return e;
   endfunction

   // memory responder: strobe order {read_a, write_a, read_b, write_b}
   initial begin : responder
      int mcnt;
      mcnt = 0;
      mem_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (memread_enable_a | memwrite_enable_a | memread_enable_b | memwrite_enable_b) begin
            mem_ready = (mem_wait >= 0) && (mcnt == mem_wait);
            mcnt++;
         end else begin
            mcnt = 0;
            mem_ready = idle_ready;
         end
      end
   end

   initial begin : monitor
      logic       halted_q;
      logic [3:0] strobes, smask;
      int         scnt;
      exp_t       e;
      halted_q = 1'b0;
      smask = '0;
      scnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            scnt = 0;
            smask = '0;
            halted_q = halted;
         end else begin
            strobes = {memread_enable_a, memwrite_enable_a, memread_enable_b, memwrite_enable_b};
            if (|strobes) begin
               scnt++;
               smask |= strobes;
            end
            if (PC_enable || (halted && !halted_q)) begin
               if (q.size() == 0) begin
                  n_checks++;
                  n_err++;
                  $display("FAIL unexpected_event: PC_enable=%0b halted=%0b with empty queue", PC_enable, halted);
               end else begin
                  e = q.pop_front();
                  check("event_is_halt", {31'd0, halted}, {31'd0, e.halt});
                  check("bus_error", {31'd0, bus_error}, {31'd0, e.berr});
                  check("latency", cyc - accept_cyc, e.lat);
                  check("strobe_cycles", scnt, e.scnt);
                  check("strobe_mask", {28'd0, smask}, {28'd0, e.smask});
                  if (e.halt) begin
                     check("halt_pc_enable", {31'd0, PC_enable}, 0);
                     check("halt_instr_ready", {31'd0, instr_ready}, 0);
                  end else begin
                     check("reg1", {27'd0, reg1}, {27'd0, e.r1});
                     check("reg2", {27'd0, reg2}, {27'd0, e.r2});
                     check("reg3", {27'd0, reg3}, {27'd0, e.r3});
                     check("s_r_amount", {27'd0, s_r_amount}, {27'd0, e.sr});
                     check("im_data", im_data, e.im);
                     check("alu_opcode", {27'd0, alu_opcode}, {27'd0, e.alu});
                     check("jump_mux", {30'd0, jump_mux_signal}, {30'd0, e.jmp});
                     check("wb_mux", {31'd0, write_back_on_register_mux_signal}, {31'd0, e.wb});
                     check("alu_in_mux", {31'd0, alu_input_mux_signal}, {31'd0, e.ain});
                     check("reg_write_word", {31'd0, register_write_word_enable}, {31'd0, e.rww});
                     check("reg_write_byte", {31'd0, register_write_byte_enable}, {31'd0, e.rwb});
                  end
               end
               scnt = 0;
               smask = '0;
            end
            halted_q = halted;
         end
      end
   end

   task automatic issue(input logic [31:0] instr, input int wait_cycles, input exp_t e);
      int n;
      mem_wait = wait_cycles;
      q.push_back(e);
      @(negedge clk);
      instruction = instr;
      instr_valid = 1'b1;
      n = 0;
      while (!instr_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) begin
         n_checks++;
         n_err++;
         $display("FAIL accept_timeout: instr_ready=0 expected 1 for 0x%08h", instr);
      end
      accept_cyc = cyc;
      @(negedge clk);
      instruction = ~instr;
      n = 0;
      while (!(PC_enable || halted) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!(PC_enable || halted)) begin
         n_checks++;
         n_err++;
         $display("FAIL completion_timeout: no PC_enable/halted expected within 100 cycles for 0x%08h", instr);
      end
      instr_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      @(negedge clk);
      check("rst_instr_ready", {31'd0, instr_ready}, 1);
      check("rst_outputs_zero", {31'd0, any_out()}, 0);
      rst = 1'b0;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int n;
`ifdef MULTICYCLE_CU_PERF_EN
      logic [31:0] retired_before;
`endif
      rst = 1'b1;
      instr_valid = 1'b0;
      instruction = '0;
      repeat (2) @(negedge clk);
      check("init_instr_ready", {31'd0, instr_ready}, 1);
      check("init_outputs_zero", {31'd0, any_out()}, 0);
      rst = 1'b0;

      // R / I / flow types
      issue(32'h0443_2940, -1, ec(3, 5, 2, 5, 32'h0000_2940, 1, 0, 1, 0, 1, 0, 3, 4'b0000, 0));
      issue(32'h58E9_8001, -1, ec(9, 0, 7, 0, 32'hFFFF_8001, 9, 0, 1, 1, 1, 0, 3, 4'b0000, 0));
      issue(32'h4C22_7FFF, -1, ec(2, 0, 1, 0, 32'h0000_7FFF, 2, 0, 1, 1, 1, 0, 3, 4'b0000, 0));
      issue(32'h5C43_0001, -1, ec(3, 0, 2, 0, 32'h0000_0001, 10, 0, 1, 1, 1, 0, 3, 4'b0000, 0));
      issue(32'h3FE0_FFC0, -1, ec(0, 31, 31, 31, 32'hFFFF_FFC0, 15, 0, 1, 0, 1, 0, 3, 4'b0000, 0));
      // memory ops with varying wait states
      issue(32'h6885_FFFC, 3, ec(5, 4, 4, 0, 32'hFFFF_FFFC, 1, 0, 0, 1, 0, 1, 7, 4'b0010, 4));
      issue(32'h6061_0010, 0, ec(1, 3, 3, 0, 32'h0000_0010, 1, 0, 0, 1, 1, 0, 4, 4'b1000, 1));
      issue(32'h6506_0004, 2, ec(6, 8, 8, 0, 32'h0000_0004, 1, 0, 0, 1, 0, 0, 6, 4'b0100, 3));
      issue(32'h6D2A_8000, 1, ec(10, 9, 9, 0, 32'hFFFF_8000, 1, 0, 0, 1, 0, 0, 5, 4'b0001, 2));
      issue(32'h77E0_0000, -1, ec(31, 0, 0, 0, 32'h0000_0000, 0, 2, 1, 0, 0, 0, 3, 4'b0000, 0));
      issue(32'h73FF_FFFF, -1, ec(31, 31, 0, 0, 32'hFFFF_FFFF, 0, 3, 1, 0, 0, 0, 3, 4'b0000, 0));
      issue(32'h7822_0008, -1, ec(1, 2, 0, 0, 32'h0000_0008, 16, 1, 1, 0, 0, 0, 3, 4'b0000, 0));
      issue(32'hFC60_0000, -1, ec(3, 0, 0, 0, 32'h0000_0000, 15, 1, 1, 0, 0, 0, 3, 4'b0000, 0));

      // reset while a store-word strobe is active
      mem_wait = -1;
      @(negedge clk);
      instruction = 32'h6506_0004;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      n = 0;
      while (!memwrite_enable_a && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("midmem_strobe_seen", {31'd0, memwrite_enable_a}, 1);
      #2 rst = 1'b1;
      #1;
      check("midmem_rst_strobe", {31'd0, memwrite_enable_a}, 0);
      check("midmem_rst_ready", {31'd0, instr_ready}, 1);
      check("midmem_rst_zero", {31'd0, any_out()}, 0);
      @(posedge clk);
      #1;
      check("midmem_rst_fetch", {31'd0, instr_ready}, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      issue(32'h0443_2940, -1, ec(3, 5, 2, 5, 32'h0000_2940, 1, 0, 1, 0, 1, 0, 3, 4'b0000, 0));

      // store word that never completes: bus error after 15 MEM cycles
      issue(32'h6506_0004, -1, eh(1, 18, 15));
      repeat (4) @(negedge clk);
      check("tmo_halted_held", {31'd0, halted}, 1);
      check("tmo_bus_error_held", {31'd0, bus_error}, 1);
      check("tmo_no_pc", {31'd0, PC_enable}, 0);
      check("tmo_ready_low", {31'd0, instr_ready}, 0);
      do_reset();

      // op 0 halts until reset
`ifdef MULTICYCLE_CU_PERF_EN
      retired_before = perf_retired;
`endif
      issue(32'h0000_0000, -1, eh(0, 2, 0));
      instr_valid = 1'b1;
      instruction = 32'h0443_2940;
      repeat (5) @(negedge clk);
      instr_valid = 1'b0;
      check("halt_held", {31'd0, halted}, 1);
      check("halt_ready_low", {31'd0, instr_ready}, 0);
      check("halt_no_pc", {31'd0, PC_enable}, 0);
`ifdef MULTICYCLE_CU_PERF_EN
      check("halt_perf_retired", perf_retired, retired_before);
`endif
      do_reset();
      issue(32'h58E9_8001, -1, ec(9, 0, 7, 0, 32'hFFFF_8001, 9, 0, 1, 1, 1, 0, 3, 4'b0000, 0));

      repeat (3) @(negedge clk);
      check("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
